// File: rtl/mult_share_arb_pkg.sv
// Shared types for mult_share_arb: FSM state encoding, requester IDs, tag format, stats width.
// The optional grant counters are enabled by defining MULT_SHARE_ARB_STATS_EN.
package mult_share_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic ID_REQ0 = 1'b0;
    localparam logic ID_REQ1 = 1'b1;

    localparam int STAT_W = 16;

    typedef struct packed {
        logic vld;
        logic id;
    } tag_t;

endpackage

// File: rtl/mult_share_arb_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, pointer register moves to the loser.
module rr_arb2
    import mult_share_arb_pkg::*;
(
    input  logic clk,
    input  logic res,
    input  logic allow,
    input  logic valid0,
    input  logic valid1,
    output logic gnt0,
    output logic gnt1
);

    logic ptr;

    always_comb begin
        gnt0 = allow & valid0 & (~valid1 | (ptr == ID_REQ0));
        gnt1 = allow & valid1 & (~valid0 | (ptr == ID_REQ1));
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            ptr <= ID_REQ0;
        end else if (gnt0) begin
            ptr <= ID_REQ1;
        end else if (gnt1) begin
            ptr <= ID_REQ0;
        end
    end

endmodule

// File: rtl/mult_share_arb.sv
// Shares one registered NxN unsigned multiplier between two requesters with round-robin issue.
// Define MULT_SHARE_ARB_STATS_EN to add saturating per-requester grant counters.
module mult_share_arb
    import mult_share_arb_pkg::*;
#(
    parameter int N   = 4,
    parameter int LAT = 1
) (
    input  logic           clk,
    input  logic           res,
    input  logic           en,
    input  logic           req0_valid,
    input  logic [N-1:0]   req0_a,
    input  logic [N-1:0]   req0_b,
    output logic           req0_ready,
    input  logic           req1_valid,
    input  logic [N-1:0]   req1_a,
    input  logic [N-1:0]   req1_b,
    output logic           req1_ready,
    output logic           rsp0_valid,
    output logic           rsp1_valid,
    output logic [2*N-1:0] rsp_prod,
    output logic           idle
`ifdef MULT_SHARE_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] gnt0_cnt,
    output logic [STAT_W-1:0] gnt1_cnt
`endif
);

    state_t         state, state_nxt;
    logic           allow;
    logic           gnt0, gnt1;
    logic           xfer;
    logic           gnt_id;
    logic           inflight;
    logic [N-1:0]   a_p0, b_p0;
    logic [2*N-1:0] mul_p0;
    logic [2*N-1:0] prod_last;
    tag_t           tag_p [LAT];

    rr_arb2 u_arb (
        .clk    (clk),
        .res    (res),
        .allow  (allow),
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .gnt0   (gnt0),
        .gnt1   (gnt1)
    );

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign xfer       = gnt0 | gnt1;
    assign gnt_id     = gnt1 ? ID_REQ1 : ID_REQ0;

    always_comb begin
        inflight = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight | tag_p[i].vld;
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (en) state_nxt = ST_RUN;
            ST_RUN:   if (!en) state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (en) begin
                    state_nxt = ST_RUN;
                end else if (!inflight) begin
                    state_nxt = ST_IDLE;
                end
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        allow = (state == ST_RUN);
        idle  = (state == ST_IDLE) && !inflight;
    end

    // stage p0: operands of the granted requester enter the multiplier
    always_ff @(posedge clk) begin
        if (xfer) begin
            a_p0 <= gnt1 ? req1_a : req0_a;
            b_p0 <= gnt1 ? req1_b : req0_b;
        end
    end

    assign mul_p0 = {{N{1'b0}}, a_p0} * {{N{1'b0}}, b_p0};

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            for (int i = 0; i < LAT; i++) begin
                tag_p[i] <= '0;
            end
        end else begin
            tag_p[0] <= '{vld: xfer, id: gnt_id};
            for (int i = 1; i < LAT; i++) begin
                tag_p[i] <= tag_p[i-1];
            end
        end
    end

    // stages p1..p(LAT-1): extra product delay so data lines up with the tag pipe
    generate
        if (LAT == 1) begin : g_lat1
            assign prod_last = mul_p0;
        end else begin : g_latn
            logic [2*N-1:0] prod_dly [LAT-1];
            always_ff @(posedge clk) begin
                prod_dly[0] <= mul_p0;
                for (int i = 1; i < LAT - 1; i++) begin
                    prod_dly[i] <= prod_dly[i-1];
                end
            end
            assign prod_last = prod_dly[LAT-2];
        end
    endgenerate

    // output stage: demux completion to its owner, hold product between completions
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp_prod   <= '0;
        end else begin
            rsp0_valid <= tag_p[LAT-1].vld && (tag_p[LAT-1].id == ID_REQ0);
            rsp1_valid <= tag_p[LAT-1].vld && (tag_p[LAT-1].id == ID_REQ1);
            if (tag_p[LAT-1].vld) begin
                rsp_prod <= prod_last;
            end
        end
    end

`ifdef MULT_SHARE_ARB_STATS_EN
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            gnt0_cnt <= '0;
            gnt1_cnt <= '0;
        end else begin
            if (gnt0) gnt0_cnt <= sat_inc(gnt0_cnt);
            if (gnt1) gnt1_cnt <= sat_inc(gnt1_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_mult_share_arb.sv
// Self-checking bench for mult_share_arb: grant vector table, scoreboard on products, corner sequences.
// Stats checks run only when MULT_SHARE_ARB_STATS_EN is defined.
module tb_mult_share_arb;

    localparam int N   = 4;
    localparam int LAT = 1;

    logic       clk;
    logic       res;
    logic       en;
    logic       req0_valid, req1_valid;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic       req0_ready, req1_ready;
    logic       rsp0_valid, rsp1_valid;
    logic [7:0] rsp_prod;
    logic       idle;
`ifdef MULT_SHARE_ARB_STATS_EN
    logic [15:0] gnt0_cnt, gnt1_cnt;
`endif

    mult_share_arb #(.N(N), .LAT(LAT)) dut (
        .clk        (clk),
        .res        (res),
        .en         (en),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .rsp0_valid (rsp0_valid),
        .rsp1_valid (rsp1_valid),
        .rsp_prod   (rsp_prod),
        .idle       (idle)
`ifdef MULT_SHARE_ARB_STATS_EN
        ,
        .gnt0_cnt   (gnt0_cnt),
        .gnt1_cnt   (gnt1_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int rsp0_cnt = 0;
    int rsp1_cnt = 0;

    typedef struct {
        logic       id;
        logic [7:0] prod;
    } exp_t;
    exp_t sb [$];

    typedef struct {
        logic       v0;
        logic [3:0] a0, b0;
        logic       v1;
        logic [3:0] a1, b1;
        logic       r0, r1;
    } vec_t;
    vec_t vecs [8];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [3:0] a0, input logic [3:0] b0,
                         input logic v1, input logic [3:0] a1, input logic [3:0] b1);
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
    endtask

    task automatic do_reset();
        res = 1'b0;
        en  = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        res = 1'b1;
    endtask

    // scoreboard: completions checked first, then new transfers queued with their products
    always @(negedge clk) begin
        if (!res) begin
            sb.delete();
        end else begin
            if (rsp0_valid && rsp1_valid) begin
                chk("rsp_exclusive", 32'(rsp0_valid & rsp1_valid), 0);
            end
            if (req0_ready && req1_ready) begin
                chk("ready_exclusive", 32'(req0_ready & req1_ready), 0);
            end
            if (rsp0_valid || rsp1_valid) begin
                if (rsp0_valid) rsp0_cnt++;
                if (rsp1_valid) rsp1_cnt++;
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 32'(rsp0_valid | rsp1_valid), 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rsp_owner", 32'(rsp1_valid), 32'(e.id));
                    chk("rsp_prod", 32'(rsp_prod), 32'(e.prod));
                end
            end
            if (req0_valid && req0_ready)
                sb.push_back('{id: 1'b0, prod: {4'b0, req0_a} * {4'b0, req0_b}});
            if (req1_valid && req1_ready)
                sb.push_back('{id: 1'b1, prod: {4'b0, req1_a} * {4'b0, req1_b}});
        end
    end

    initial begin
        repeat (200000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int c0, c1;
        logic [7:0] pair;

        vecs[0] = '{1, 3, 5,   0, 0, 0,    1, 0};
        vecs[1] = '{1, 2, 7,   1, 15, 15,  0, 1};
        vecs[2] = '{1, 2, 7,   1, 15, 15,  1, 0};
        vecs[3] = '{1, 0, 9,   0, 0, 0,    1, 0};
        vecs[4] = '{1, 15, 15, 1, 0, 0,    0, 1};
        vecs[5] = '{0, 0, 0,   1, 8, 8,    0, 1};
        vecs[6] = '{0, 0, 0,   0, 0, 0,    0, 0};
        vecs[7] = '{1, 1, 1,   1, 15, 1,   1, 0};

        // reset state and single request from requester 0
        do_reset();
        drive(1, 3, 5, 0, 0, 0);
        #1;
        chk("rst_rsp0", 32'(rsp0_valid), 0);
        chk("rst_rsp1", 32'(rsp1_valid), 0);
        chk("rst_prod", 32'(rsp_prod), 0);
        chk("rst_idle", 32'(idle), 1);
        chk("idle_holdoff_ready0", 32'(req0_ready), 0);
        en = 1'b1;
        tick();
        #1;
        chk("t1_ready0", 32'(req0_ready), 1);
        chk("t1_idle_run", 32'(idle), 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("t1_rsp_not_yet", 32'(rsp0_valid), 0);
        tick();
        #1;
        chk("t1_rsp0", 32'(rsp0_valid), 1);
        chk("t1_prod", 32'(rsp_prod), 15);
        tick();
        #1;
        chk("t1_pulse_end", 32'(rsp0_valid), 0);
        chk("t1_prod_hold", 32'(rsp_prod), 15);

        // both requesters continuously valid: strict alternation, one product per cycle
        do_reset();
        en = 1'b1;
        tick();
        drive(1, 2, 7, 1, 15, 15);
        c0 = rsp0_cnt; c1 = rsp1_cnt;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("t2_ready0", 32'(req0_ready), 32'(i % 2 == 0));
            chk("t2_ready1", 32'(req1_ready), 32'(i % 2 == 1));
            if (i >= 2) begin
                chk("t2_alt_rsp0", 32'(rsp0_valid), 32'(i % 2 == 0));
                chk("t2_alt_prod", 32'(rsp_prod), (i % 2 == 0) ? 14 : 225);
            end
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk("t2_rsp0_cnt", 32'(rsp0_cnt - c0), 4);
        chk("t2_rsp1_cnt", 32'(rsp1_cnt - c1), 4);

        // grant table from a freshly reset pointer
        do_reset();
        en = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].v0, vecs[i].a0, vecs[i].b0, vecs[i].v1, vecs[i].a1, vecs[i].b1);
            #1;
            chk($sformatf("vec%0d_ready0", i), 32'(req0_ready), 32'(vecs[i].r0));
            chk($sformatf("vec%0d_ready1", i), 32'(req1_ready), 32'(vecs[i].r1));
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();

        // every operand pair through requester 1, back to back
        c1 = rsp1_cnt;
        for (int i = 0; i < 256; i++) begin
            pair = 8'(i);
            drive(0, 0, 0, 1, pair[7:4], pair[3:0]);
            #1;
            chk("t3_ready1", 32'(req1_ready), 1);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        chk("t3_rsp1_cnt", 32'(rsp1_cnt - c1), 256);

        // drop en with an op in flight
        drive(1, 6, 6, 0, 0, 0);
        #1;
        chk("t4_ready0", 32'(req0_ready), 1);
        tick();
        en = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 7, 7, 0, 0, 0);
        #1;
        chk("t4_ready_off", 32'(req0_ready), 0);
        chk("t4_drain_rsp0", 32'(rsp0_valid), 1);
        chk("t4_drain_prod", 32'(rsp_prod), 36);
        chk("t4_not_idle", 32'(idle), 0);
        tick();
        #1;
        chk("t4_idle", 32'(idle), 1);
        chk("t4_ready_idle", 32'(req0_ready), 0);
        drive(0, 0, 0, 0, 0, 0);

        // reset between transfer and completion
        en = 1'b1;
        tick();
        drive(1, 9, 9, 0, 0, 0);
        #1;
        chk("t5_ready0", 32'(req0_ready), 1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        res = 1'b0;
        en  = 1'b0;
        #1;
        chk("t5_rsp0", 32'(rsp0_valid), 0);
        chk("t5_prod", 32'(rsp_prod), 0);
        chk("t5_idle", 32'(idle), 1);
        tick();
        #1;
        chk("t5_rsp0_held", 32'(rsp0_valid), 0);
        res = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            chk("t5_no_pulse", 32'(rsp0_valid | rsp1_valid), 0);
        end
        en = 1'b1;
        tick();
        drive(1, 4, 4, 1, 5, 5);
        #1;
        chk("t5_ptr_ready0", 32'(req0_ready), 1);
        chk("t5_ptr_ready1", 32'(req1_ready), 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick();

`ifdef MULT_SHARE_ARB_STATS_EN
        do_reset();
        #1;
        chk("st_rst0", 32'(gnt0_cnt), 0);
        en = 1'b1;
        tick();
        drive(1, 1, 2, 0, 0, 0);
        repeat (5) tick();
        drive(0, 0, 0, 1, 3, 4);
        repeat (3) tick();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("st_gnt0", 32'(gnt0_cnt), 5);
        chk("st_gnt1", 32'(gnt1_cnt), 3);
        drive(1, 1, 1, 0, 0, 0);
        repeat (65536) tick();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("st_gnt0_sat", 32'(gnt0_cnt), 32'hFFFF);
        chk("st_gnt1_keep", 32'(gnt1_cnt), 3);
`endif

        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        chk("sb_drained", 32'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
